// File: rtl/prog_fetch_unit.sv
// Writable multi-program instruction store with a fetch sequencer that hands one
// instruction at a time to the decoder over a valid/ready handshake.
module prog_fetch_unit #(
  parameter int unsigned     INSTR_W = 8,
  parameter int unsigned     OPC_W   = 4,
  parameter int unsigned     ADDR_W  = 8,
  parameter int unsigned     PROG_W  = 2,
  parameter logic [OPC_W-1:0] HALT_OP = 4'hF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [PROG_W-1:0]  prog_sel,
  input  logic               abort,
  input  logic               wr_en,
  input  logic [PROG_W-1:0]  wr_prog,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [INSTR_W-1:0] wr_data,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               busy,
  output logic               done,
  output logic [1:0]         end_code
);

  localparam int unsigned        SEL_W   = PROG_W + ADDR_W;
  localparam int unsigned        DEPTH   = 2 ** SEL_W;
  localparam logic [ADDR_W-1:0]  LAST_PC = '1;

  typedef enum logic [1:0] {StIdle, StFetch, StPresent, StDone} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [PROG_W-1:0]   prog_q;
  logic [INSTR_W-1:0]  mem [DEPTH];
  logic [DEPTH-1:0]    wvalid_q;
  logic [SEL_W-1:0]    rd_addr;
  logic [SEL_W-1:0]    wr_sel;
  logic [INSTR_W-1:0]  rd_data;
  logic                rd_valid;

  assign wr_sel   = {wr_prog, wr_addr};
  assign rd_addr  = {prog_q, pc_q};
  assign rd_data  = mem[rd_addr];
  assign rd_valid = wvalid_q[rd_addr];
  assign busy     = (state_q != StIdle);

  // Data contents are not reset; only the per-word valid bits are.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_sel] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wvalid_q <= '0;
    end else if (wr_en) begin
      wvalid_q[wr_sel] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      prog_q      <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      done        <= 1'b0;
      end_code    <= 2'd0;
    end else begin
      done <= 1'b0;
      // Abort wins over acceptance and leaves end_code untouched.
      if (abort && (state_q != StIdle)) begin
        state_q     <= StIdle;
        instr_valid <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start) begin
              prog_q  <= prog_sel;
              pc_q    <= '0;
              state_q <= StFetch;
            end
          end
          StFetch: begin
            if (rd_valid) begin
              instr       <= rd_data;
              instr_pc    <= pc_q;
              instr_valid <= 1'b1;
              state_q     <= StPresent;
            end else begin
              end_code <= 2'd1;
              done     <= 1'b1;
              state_q  <= StDone;
            end
          end
          StPresent: begin
            if (instr_ready) begin
              instr_valid <= 1'b0;
              if (instr[INSTR_W-1 -: OPC_W] == HALT_OP) begin
                end_code <= 2'd0;
                done     <= 1'b1;
                state_q  <= StDone;
              end else if (pc_q == LAST_PC) begin
                end_code <= 2'd2;
                done     <= 1'b1;
                state_q  <= StDone;
              end else begin
                pc_q    <= pc_q + 1'b1;
                state_q <= StFetch;
              end
            end
          end
          StDone: state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule
